// File: rtl/corral_display_pkg.sv
// corral_pkg: shared types and glyph constants for the Corral display path.
//   pos_t        - 4-bit position as produced by the game core
//   state_t      - display sequencer states (gap states only with
//                  CORRAL_DISPLAY_GAP_EN defined)
//   GLYPH_*      - seven-segment patterns, segments a..g on bits 0..6
//   DIGIT_TABLE  - decimal digit patterns, indexed by digit value
package corral_pkg;

  typedef logic [3:0] pos_t;

  typedef enum logic [2:0] {
    LOAD,
    SHOW_C,
`ifdef CORRAL_DISPLAY_GAP_EN
    GAP_C,
`endif
    SHOW_H,
`ifdef CORRAL_DISPLAY_GAP_EN
    GAP_H,
`endif
    END
  } state_t;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_L     = 7'h38;
  localparam logic [6:0] GLYPH_H     = 7'h76;

  // Leftmost entry is index 9.
  localparam logic [9:0][6:0] DIGIT_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/corral_display_if.sv
// corral_display_if: game-core-to-display signal bundle.
//   cowboypos, horsepos - positions from the game core (0..9, 15 = off board)
//   gameover, lostwon   - end-of-game level and result (1 = won)
//   seg, dp             - seven-segment drive and decimal point
// master: game side (drives positions/flags). slave: display side.
interface corral_display_if;

  corral_pkg::pos_t cowboypos;
  corral_pkg::pos_t horsepos;
  logic             gameover;
  logic             lostwon;
  logic [6:0]       seg;
  logic             dp;

  modport master (
    output cowboypos, horsepos, gameover, lostwon,
    input  seg, dp
  );

  modport slave (
    input  cowboypos, horsepos, gameover, lostwon,
    output seg, dp
  );

endinterface

// File: rtl/corral_display_seg7_decode.sv
// seg7_decode: combinational position-to-seven-segment decoder.
//   pos_i - position value
//   seg_o - segments a..g on bits 0..6; dash for values above 9
module seg7_decode
  import corral_pkg::*;
(
  input  pos_t       pos_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_DASH;
    if (pos_i <= 4'd9) begin
      seg_o = DIGIT_TABLE[pos_i];
    end
  end

endmodule

// File: rtl/corral_display.sv
// corral_display: Corral seven-segment output stage.
// Shows the latched cowboy digit, then the horse digit (dp lit), once per
// round; after game over shows a blinking H (won) or L (lost) glyph.
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high
//   bus (slave)  - positions and flags in, seg/dp out
// Parameter DWELL_CYCLES (>= 2): cycles per digit, gap or blink phase.
// Macro CORRAL_DISPLAY_GAP_EN: inserts a blank phase after each digit.
module corral_display
  import corral_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  corral_display_if.slave  bus
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pos_t             cow_q, cow_d;
  pos_t             horse_q, horse_d;
  logic             result_q, result_d;
  logic             blink_q, blink_d;

  logic             last;
  pos_t             dec_pos;
  logic [6:0]       dec_seg;

  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      cow_q    <= '0;
      horse_q  <= '0;
      result_q <= 1'b0;
      blink_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cow_q    <= cow_d;
      horse_q  <= horse_d;
      result_q <= result_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cow_d    = cow_q;
    horse_d  = horse_q;
    result_d = result_q;
    blink_d  = blink_q;
    cnt_d    = last ? '0 : cnt_q + CNT_W'(1);

    // Game over wins over any phase terminal count.
    if (bus.gameover && (state_q != END)) begin
      state_d  = END;
      cnt_d    = '0;
      blink_d  = 1'b1;
      result_d = bus.lostwon;
    end else begin
      case (state_q)
        LOAD: begin
          cow_d   = bus.cowboypos;
          horse_d = bus.horsepos;
          cnt_d   = '0;
          state_d = SHOW_C;
        end
`ifdef CORRAL_DISPLAY_GAP_EN
        SHOW_C: if (last) state_d = GAP_C;
        GAP_C:  if (last) state_d = SHOW_H;
        SHOW_H: if (last) state_d = GAP_H;
        GAP_H:  if (last) state_d = LOAD;
`else
        SHOW_C: if (last) state_d = SHOW_H;
        SHOW_H: if (last) state_d = LOAD;
`endif
        END: begin
          if (!bus.gameover) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else if (last) begin
            blink_d = ~blink_q;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  assign dec_pos = (state_q == SHOW_H) ? horse_q : cow_q;

  seg7_decode u_decode (
    .pos_i (dec_pos),
    .seg_o (dec_seg)
  );

  always_comb begin
    bus.seg = GLYPH_BLANK;
    bus.dp  = 1'b0;
    case (state_q)
      SHOW_C: bus.seg = dec_seg;
      SHOW_H: begin
        bus.seg = dec_seg;
        bus.dp  = 1'b1;
      end
      END: if (blink_q) bus.seg = result_q ? GLYPH_H : GLYPH_L;
      default: ;
    endcase
  end

endmodule
